pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 7, meaning points needed to win (1..2**SCORE_W-1).
REQ-002 The block SHALL have parameter SERVE_DELAY, default 60, meaning frame_tick pulses spent in SERVE before play (>=1).
REQ-003 The block SHALL have parameter SCORE_W, default 4, meaning score counter width.
REQ-004 The block SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-007 The block SHALL have port start_btn  input  1  synchronized level, start/restart request.
REQ-008 The block SHALL have port pause_btn  input  1  synchronized level, pause toggle.
REQ-009 The block SHALL have ports miss_left, miss_right  input  1 each  one-cycle pulses: ball passed left/right edge.
REQ-010 The block SHALL have port state  output  3  current FSM state encoding.
REQ-011 The block SHALL have ports paddle_rst, ball_rst  output  1 each  recentre paddles/ball.
REQ-012 The block SHALL have ports paddle_en, ball_en  output  1 each  movement enables.
REQ-013 The block SHALL have port serve_dir  output  1  0 = ball served leftward, 1 = rightward.
REQ-014 The block SHALL have ports score_left, score_right  output  SCORE_W each  current scores.
REQ-015 The block SHALL have port winner  output  2  00 none, 01 left, 10 right.

Function
REQ-016 States SHALL be IDLE, SERVE, PLAY, PAUSE, POINT, GAMEOVER.
REQ-017 start_btn and pause_btn SHALL act only on rising edges (registered previous value), one edge = one event.
REQ-018 IDLE: paddle_rst=1, ball_rst=1, enables 0; start edge -> SERVE, scores cleared, winner=00, serve_dir=0, next cycle.
REQ-019 SERVE: ball_rst=1, paddle_en=1, ball_en=0; serve counter loaded with SERVE_DELAY on entry, decremented per frame_tick; frame_tick with counter==1 -> PLAY.
REQ-020 PLAY: ball_en=1, paddle_en=1; miss_left -> score_right+1 -> POINT; miss_right -> score_left+1 -> POINT.
REQ-021 PLAY with miss_left and miss_right in same cycle: no score change, serve_dir unchanged, -> SERVE (replay).
REQ-022 PLAY miss pulse takes priority over a simultaneous pause edge.
REQ-023 PLAY pause edge (no miss) -> PAUSE; PAUSE: all enables 0, positions held (no rst), miss inputs ignored; pause edge -> PLAY.
REQ-024 POINT lasts exactly one cycle: if either score == WIN_SCORE -> GAMEOVER, winner set; else -> SERVE with serve_dir toward the player who conceded (miss_left -> 0, miss_right -> 1).
REQ-025 GAMEOVER: enables 0, scores and winner held; start edge -> SERVE with scores cleared, winner=00.
REQ-026 Scores SHALL never exceed WIN_SCORE; no wrap-around.
REQ-027 start_btn edge in SERVE/PLAY/PAUSE/POINT SHALL be ignored.
REQ-028 All outputs SHALL be registered or decoded from registered state only; latency from event to output change = 1 cycle.

Reset
REQ-029 rst SHALL force state=IDLE, scores=0, winner=00, serve_dir=0, serve counter=0, edge registers=0; wins over all other inputs, mid-game included.
REQ-030 During rst cycle and after, paddle_rst=ball_rst=1, paddle_en=ball_en=0.

Structure
REQ-031 State enum, winner encoding and default parameter constants SHALL live in shared package pong_pkg.
REQ-032 Rising-edge detection SHALL be a sub-module btn_edge, instantiated once per button.

Verification
REQ-033 Reset then start edge -> SERVE next cycle; after 60 frame_ticks -> PLAY, ball_en=1.
REQ-034 PLAY, miss_right pulse -> score_left 0->1, POINT one cycle, SERVE with serve_dir=1.
REQ-035 PLAY, miss_left and miss_right same cycle -> scores unchanged, SERVE.
REQ-036 Score 6-0 left, miss_right -> score_left=7, GAMEOVER, winner=01; further misses ignored; start edge -> scores 0, SERVE.
REQ-037 PLAY, pause edge -> PAUSE, enables 0, miss_left ignored; pause edge -> PLAY, scores unchanged.
REQ-038 rst asserted in PLAY at 3-2 -> next cycle IDLE, scores 0, winner 00.

Source files
------------

// File: rtl/pong_pkg.sv
// Pong controller shared types: FSM state and winner encodings
// plus the default game parameters.
package pong_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_PAUSE    = 3'd3,
    S_POINT    = 3'd4,
    S_GAMEOVER = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LEFT  = 2'b01,
    WIN_RIGHT = 2'b10
  } winner_e;

  localparam int DEF_WIN_SCORE   = 7;
  localparam int DEF_SERVE_DELAY = 60;
  localparam int DEF_SCORE_W     = 4;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a synchronized button level.
// Ports: clk, rst, btn_i (level), rise_o (1 on first high cycle).
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= btn_i;
  end

  assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/pause/point/gameover FSM, scores.
// Ports: clk, rst, frame_tick, start/pause buttons, miss pulses in;
// state, paddle/ball reset+enable, serve_dir, scores, winner out.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int SERVE_DELAY = DEF_SERVE_DELAY,
  parameter int SCORE_W     = DEF_SCORE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic [2:0]         state,
  output logic               paddle_rst,
  output logic               ball_rst,
  output logic               paddle_en,
  output logic               ball_en,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic [1:0]         winner
);

  localparam int CNT_W = $clog2(SERVE_DELAY + 1);
  localparam logic [CNT_W-1:0] SD = CNT_W'(SERVE_DELAY);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  logic start_e;
  logic pause_e;

  btn_edge u_start (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (start_btn),
    .rise_o (start_e)
  );

  btn_edge u_pause (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (pause_btn),
    .rise_o (pause_e)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] sl_q, sl_d;
  logic [SCORE_W-1:0] sr_q, sr_d;
  winner_e            win_q, win_d;
  logic               dir_q, dir_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sl_q    <= '0;
      sr_q    <= '0;
      win_q   <= WIN_NONE;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      win_q   <= win_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    win_d   = win_q;
    dir_d   = dir_q;
    unique case (state_q)
      S_IDLE, S_GAMEOVER: begin
        if (start_e) begin
          state_d = S_SERVE;
          cnt_d   = SD;
          sl_d    = '0;
          sr_d    = '0;
          win_d   = WIN_NONE;
          dir_d   = 1'b0;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // Misses outrank a pause edge; a double miss is a replay.
        if (miss_left && miss_right) begin
          state_d = S_SERVE;
          cnt_d   = SD;
        end else if (miss_left) begin
          if (sr_q < WIN) sr_d = sr_q + SCORE_W'(1);
          dir_d   = 1'b0;
          state_d = S_POINT;
        end else if (miss_right) begin
          if (sl_q < WIN) sl_d = sl_q + SCORE_W'(1);
          dir_d   = 1'b1;
          state_d = S_POINT;
        end else if (pause_e) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_e) state_d = S_PLAY;
      end
      S_POINT: begin
        if (sl_q == WIN) begin
          state_d = S_GAMEOVER;
          win_d   = WIN_LEFT;
        end else if (sr_q == WIN) begin
          state_d = S_GAMEOVER;
          win_d   = WIN_RIGHT;
        end else begin
          state_d = S_SERVE;
          cnt_d   = SD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // rst is folded in so the recentre/disable holds in the reset cycle.
  always_comb begin
    paddle_rst = rst | (state_q == S_IDLE);
    ball_rst   = rst | (state_q == S_IDLE) | (state_q == S_SERVE);
    paddle_en  = ~rst & ((state_q == S_SERVE) | (state_q == S_PLAY));
    ball_en    = ~rst & (state_q == S_PLAY);
  end

  assign state       = state_q;
  assign serve_dir   = dir_q;
  assign score_left  = sl_q;
  assign score_right = sr_q;
  assign winner      = win_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl.
// Uses default parameters (WIN 7, SERVE_DELAY 60, SCORE_W 4).
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic [2:0] state;
  logic       paddle_rst, ball_rst, paddle_en, ball_en, serve_dir;
  logic [3:0] score_left, score_right;
  logic [1:0] winner;

  localparam int IDLE = 0, SERVE = 1, PLAY = 2;
  localparam int PAUSE = 3, POINT = 4, OVER = 5;

  int n_chk = 0;
  int n_err = 0;

  pong_game_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .start_btn   (start_btn),
    .pause_btn   (pause_btn),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .state       (state),
    .paddle_rst  (paddle_rst),
    .ball_rst    (ball_rst),
    .paddle_en   (paddle_en),
    .ball_en     (ball_en),
    .serve_dir   (serve_dir),
    .score_left  (score_left),
    .score_right (score_right),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input int act,
                           input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
  endtask

  task automatic press_pause();
    pause_btn = 1'b1;
    tick();
    pause_btn = 1'b0;
  endtask

  // 60 frame pulses, one every other cycle, from SERVE entry.
  task automatic serve_to_play(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (i == 59)
        expect_eq({tag, "_pre"}, int'(state), SERVE);
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
    end
    expect_eq(tag, int'(state), PLAY);
  endtask

  // Miss in PLAY, pass through POINT, land in SERVE.
  task automatic score_point(input logic left_missed);
    miss_left  = left_missed;
    miss_right = ~left_missed;
    tick();
    miss_left  = 1'b0;
    miss_right = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    #1;
    expect_eq("rst_paddle_rst", int'(paddle_rst), 1);
    expect_eq("rst_ball_en", int'(ball_en), 0);
    tick();
    tick();
    rst = 1'b0;
    expect_eq("reset_state", int'(state), IDLE);
    expect_eq("reset_scores", int'({score_left, score_right}), 0);
    expect_eq("reset_winner", int'(winner), 0);
    expect_eq("idle_ball_rst", int'(ball_rst), 1);
    expect_eq("idle_paddle_en", int'(paddle_en), 0);

    press_start();
    expect_eq("start_serve", int'(state), SERVE);
    expect_eq("serve_dir0", int'(serve_dir), 0);
    expect_eq("serve_ball_en", int'(ball_en), 0);
    expect_eq("serve_paddle_en", int'(paddle_en), 1);
    serve_to_play("serve1");
    expect_eq("play_ball_en", int'(ball_en), 1);

    press_start();
    expect_eq("start_ignored", int'(state), PLAY);

    miss_right = 1'b1;
    tick();
    miss_right = 1'b0;
    expect_eq("point_state", int'(state), POINT);
    expect_eq("point_sl", int'(score_left), 1);
    tick();
    expect_eq("after_point", int'(state), SERVE);
    expect_eq("dir_right", int'(serve_dir), 1);

    serve_to_play("serve2");
    miss_left  = 1'b1;
    miss_right = 1'b1;
    tick();
    miss_left  = 1'b0;
    miss_right = 1'b0;
    expect_eq("dbl_state", int'(state), SERVE);
    expect_eq("dbl_sl", int'(score_left), 1);
    expect_eq("dbl_sr", int'(score_right), 0);
    expect_eq("dbl_dir", int'(serve_dir), 1);

    for (int k = 0; k < 5; k++) begin
      serve_to_play("serve_run");
      score_point(1'b0);
    end
    expect_eq("six_zero", int'(score_left), 6);
    serve_to_play("serve_final");
    miss_right = 1'b1;
    tick();
    miss_right = 1'b0;
    expect_eq("seven", int'(score_left), 7);
    tick();
    expect_eq("gameover", int'(state), OVER);
    expect_eq("winner_left", int'(winner), 1);
    expect_eq("over_en", int'({paddle_en, ball_en}), 0);
    miss_left = 1'b1;
    tick();
    miss_left = 1'b0;
    miss_right = 1'b1;
    tick();
    miss_right = 1'b0;
    expect_eq("over_hold", int'(state), OVER);
    expect_eq("over_sl", int'(score_left), 7);
    expect_eq("over_sr", int'(score_right), 0);
    press_start();
    expect_eq("restart", int'(state), SERVE);
    expect_eq("restart_sc", int'({score_left, score_right}), 0);
    expect_eq("restart_win", int'(winner), 0);

    serve_to_play("serve3");
    press_pause();
    expect_eq("pause", int'(state), PAUSE);
    expect_eq("pause_en", int'({paddle_en, ball_en}), 0);
    expect_eq("pause_rst", int'({paddle_rst, ball_rst}), 0);
    tick();
    miss_left = 1'b1;
    tick();
    miss_left = 1'b0;
    expect_eq("pause_miss", int'(state), PAUSE);
    expect_eq("pause_sr", int'(score_right), 0);
    press_pause();
    expect_eq("resume", int'(state), PLAY);
    expect_eq("resume_sc", int'({score_left, score_right}), 0);
    tick();

    miss_left = 1'b1;
    pause_btn = 1'b1;
    tick();
    miss_left = 1'b0;
    pause_btn = 1'b0;
    expect_eq("prio_state", int'(state), POINT);
    expect_eq("prio_sr", int'(score_right), 1);
    tick();
    expect_eq("dir_left", int'(serve_dir), 0);

    for (int k = 0; k < 3; k++) begin
      serve_to_play("serve_l");
      score_point(1'b0);
    end
    serve_to_play("serve_r");
    score_point(1'b1);
    serve_to_play("serve_last");
    expect_eq("pre_rst_sl", int'(score_left), 3);
    expect_eq("pre_rst_sr", int'(score_right), 2);
    rst = 1'b1;
    miss_left = 1'b1;
    tick();
    rst = 1'b0;
    miss_left = 1'b0;
    expect_eq("midrst_state", int'(state), IDLE);
    expect_eq("midrst_sc", int'({score_left, score_right}), 0);
    expect_eq("midrst_win", int'(winner), 0);
    expect_eq("midrst_dir", int'(serve_dir), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
